despliegue_resultado: RTL and testbench

Output-side counterpart of the switch/pushbutton input stage. It accepts the 16-bit product from the sequential multiplier through a valid/busy handshake and converts it to five BCD digits sequentially (double dabble). It drives the board's 8-digit common-anode 7-segment display with time-multiplexing and leading-zero blanking. It sits between the multiplier core and the board pins.

---
 rtl/despliegue_pkg.sv | 24 ++
 rtl/despliegue_resultado_bin_a_bcd.sv | 84 ++++++++
 rtl/despliegue_resultado.sv | 134 +++++++++++++
 tb/tb_despliegue_resultado.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/despliegue_pkg.sv
// Shared types and constants for the result display path: FSM states,
// the BCD digit type and the active-low 7-segment code table.
package despliegue_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CONVERTIR = 2'd1,
    CARGAR    = 2'd2
  } estado_t;

  typedef logic [3:0] digito_t;

  localparam int N_DIGITOS = 5;
  localparam int BCD_W     = 4 * N_DIGITOS;

  // Segment patterns {g,f,e,d,c,b,a}, active-low, indexed by decimal digit.
  localparam logic [6:0] SEG_CODE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/despliegue_resultado_bin_a_bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock.
// 'done' is high during the cycle whose edge performs the last iteration,
// so bcd holds the final result from the following cycle onward.
module bin_a_bcd
  import despliegue_pkg::*;
#(
  parameter int N_BITS = 16
) (
  input  logic              Clk_100M,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IW-1:0] ULTIMA = IW'(N_BITS - 1);

  estado_t           estado_q, estado_d;
  logic [N_BITS-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  bcd_adj;
  logic [IW-1:0]     iter_q, iter_d;
  logic              done_d;

  // Add 3 to every nibble that is 5 or more before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITOS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      estado_q <= REPOSO;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
    end else begin
      estado_q <= estado_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
    end
  end

  // Next-state: capture on start, then iterate N_BITS times.
  always_comb begin
    estado_d = estado_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    done_d   = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (start) begin
          bin_d    = bin;
          bcd_d    = '0;
          iter_d   = '0;
          estado_d = CONVERTIR;
        end
      end
      CONVERTIR: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d = iter_q + 1'b1;
        if (iter_q == ULTIMA) begin
          estado_d = REPOSO;
          done_d   = 1'b1;
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  assign busy = (estado_q == CONVERTIR);
  assign done = done_d;
  assign bcd  = bcd_q;

endmodule

// File: rtl/despliegue_resultado.sv
// Result display: takes a product via valid/busy handshake, converts it to
// BCD, latches it atomically and time-multiplexes it onto an 8-digit
// common-anode display with leading-zero blanking.
module despliegue_resultado
  import despliegue_pkg::*;
#(
  parameter int REFRESH_DIV = 99999,
  parameter int N_BITS      = 16
) (
  input  logic              Clk_100M,
  input  logic              reset,
  input  logic [N_BITS-1:0] producto,
  input  logic              producto_valido,
  output logic              ocupado,
  output logic              listo,
  output logic [7:0]        AN,
  output logic [6:0]        SEG,
  output logic              DP
);

  localparam int REF_W = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV);

  estado_t          estado_q, estado_d;
  logic             listo_q, listo_d;
  logic [BCD_W-1:0] disp_q, disp_d;
  logic [REF_W-1:0] ref_q;
  logic [2:0]       idx_q;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;

  digito_t          dig [N_DIGITOS];
  logic [N_DIGITOS-1:0] vis;

  // Strobes arriving while a conversion or load is pending are dropped.
  assign conv_start = producto_valido && (estado_q == REPOSO);

  bin_a_bcd #(.N_BITS(N_BITS)) u_bin_a_bcd (
    .Clk_100M (Clk_100M),
    .reset    (reset),
    .start    (conv_start),
    .bin      (producto),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd)
  );

  // Control state, handshake pulse and display value registers.
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      estado_q <= REPOSO;
      listo_q  <= 1'b0;
      disp_q   <= '0;
    end else begin
      estado_q <= estado_d;
      listo_q  <= listo_d;
      disp_q   <= disp_d;
    end
  end

  // Wait for the converter, then load the display in a single cycle.
  always_comb begin
    estado_d = estado_q;
    listo_d  = 1'b0;
    disp_d   = disp_q;
    case (estado_q)
      REPOSO:    if (producto_valido) estado_d = CONVERTIR;
      CONVERTIR: if (conv_done) estado_d = CARGAR;
      CARGAR: begin
        disp_d   = conv_bcd;
        listo_d  = 1'b1;
        estado_d = REPOSO;
      end
      default:   estado_d = REPOSO;
    endcase
  end

  assign ocupado = conv_busy || (estado_q == CARGAR);
  assign listo   = listo_q;

  // Refresh prescaler and digit-slot index; the 3-bit index wraps 7 -> 0.
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      ref_q <= '0;
      idx_q <= '0;
    end else if (ref_q == REF_MAX) begin
      ref_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  // A digit is visible when it or any more significant digit is nonzero;
  // the units digit is always visible.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITOS; gi++) begin : g_dig
      assign dig[gi] = disp_q[4*gi +: 4];
      assign vis[gi] = (gi == 0) || (disp_q[BCD_W-1:4*gi] != '0);
    end
  endgenerate

  // Anode/segment pattern for the current slot; slots 5-7 stay dark.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    if (idx_q < 3'd5) begin
      if (vis[idx_q]) begin
        an_d  = ~(8'b1 << idx_q);
        seg_d = (dig[idx_q] <= 4'd9) ? SEG_CODE[dig[idx_q]] : SEG_BLANK;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = 1'b1;

endmodule

// File: tb/tb_despliegue_resultado.sv
// Bench for despliegue_resultado: directed and random products, checking
// handshake latency and the displayed frame against a decimal model.
module tb_despliegue_resultado;

  localparam int RD = 3;

  logic        Clk_100M = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] producto = '0;
  logic        producto_valido = 1'b0;
  logic        ocupado, listo, DP;
  logic [7:0]  AN;
  logic [6:0]  SEG;

  int errors = 0;
  int checks = 0;

  int          p10 [5] = '{1, 10, 100, 1000, 10000};
  logic [6:0]  segtab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  despliegue_resultado #(.REFRESH_DIV(RD), .N_BITS(16)) dut (
    .Clk_100M        (Clk_100M),
    .reset           (reset),
    .producto        (producto),
    .producto_valido (producto_valido),
    .ocupado         (ocupado),
    .listo           (listo),
    .AN              (AN),
    .SEG             (SEG),
    .DP              (DP)
  );

  always #5 Clk_100M = ~Clk_100M;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe one full frame (8 slots x (RD+1) cycles) and compare each slot
  // with the decimal digits of v.
  task automatic check_frame(input int v, input string tag);
    bit         seen [8];
    logic [6:0] sg [8];
    int         bad;
    logic [7:0] m;
    bit         shown;
    int         d;
    bad = 0;
    for (int i = 0; i < 8; i++) begin seen[i] = 0; sg[i] = '0; end
    for (int c = 0; c < 8 * (RD + 1); c++) begin
      @(negedge Clk_100M);
      if (AN !== 8'hFF) begin
        bit hit;
        hit = 0;
        for (int i = 0; i < 8; i++) begin
          m = ~(8'b1 << i);
          if (AN === m) begin seen[i] = 1; sg[i] = SEG; hit = 1; end
        end
        if (!hit) bad++;
      end
    end
    chk($sformatf("%s_an_pattern", tag), bad, 0);
    chk($sformatf("%s_dp", tag), {31'd0, DP}, 1);
    for (int i = 0; i < 8; i++) begin
      shown = (i < 5) && ((i == 0) || (v >= p10[i]));
      chk($sformatf("%s_slot%0d_on", tag, i), {31'd0, seen[i]}, {31'd0, shown});
      if (shown) begin
        d = (v / p10[i]) % 10;
        chk($sformatf("%s_slot%0d_seg", tag, i), {25'd0, sg[i]}, {25'd0, segtab[d]});
      end
    end
    $display("frame %s value=%0d checked", tag, v);
  endtask

  // Strobe one value and check ocupado/listo timing edge by edge.
  task automatic send(input int v, input string tag);
    int early, ocu_low;
    early = 0;
    ocu_low = 0;
    @(negedge Clk_100M);
    producto = v[15:0];
    producto_valido = 1'b1;
    @(posedge Clk_100M); #1;
    producto_valido = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k < 17) begin
        if (listo !== 1'b0) early++;
        if (ocupado !== 1'b1) ocu_low++;
      end
      @(posedge Clk_100M); #1;
    end
    chk($sformatf("%s_listo_early", tag), early, 0);
    chk($sformatf("%s_ocupado_held", tag), ocu_low, 0);
    chk($sformatf("%s_listo_e17", tag), {31'd0, listo}, 1);
    chk($sformatf("%s_ocupado_e17", tag), {31'd0, ocupado}, 0);
    @(posedge Clk_100M); #1;
    chk($sformatf("%s_listo_pulse", tag), {31'd0, listo}, 0);
    $display("send %s value=%0d", tag, v);
    repeat (2) @(posedge Clk_100M);
    check_frame(v, tag);
  endtask

  initial begin
    int pulses, at_edge, v;

    // Reset held three cycles.
    reset = 1'b1;
    @(posedge Clk_100M);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk_100M);
      chk("rst_an", {24'd0, AN}, 32'hFF);
      chk("rst_seg", {25'd0, SEG}, 32'h7F);
      chk("rst_ocupado", {31'd0, ocupado}, 0);
      chk("rst_listo", {31'd0, listo}, 0);
    end
    reset = 1'b0;
    check_frame(0, "after_reset");

    send(16'hFFFF, "max");
    send(16'hFE01, "fe01");
    send(10, "ten");
    send(0, "zero");

    for (int n = 0; n < 6; n++) begin
      v = int'($urandom_range(0, 65535));
      send(v, $sformatf("rand%0d", n));
    end

    // Second strobe while busy must be dropped.
    @(negedge Clk_100M);
    producto = 16'd7;
    producto_valido = 1'b1;
    @(posedge Clk_100M); #1;
    producto_valido = 1'b0;
    pulses = 0;
    at_edge = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge Clk_100M); #1;
      if (listo === 1'b1) begin pulses++; at_edge = k; end
      if (k == 5) begin producto = 16'd9; producto_valido = 1'b1; end
      if (k == 6) producto_valido = 1'b0;
    end
    chk("busy_drop_pulses", pulses, 1);
    chk("busy_drop_edge", at_edge, 17);
    $display("send busy_drop value=7 second=9 pulses=%0d", pulses);
    check_frame(7, "busy_drop");

    // Reset at edge 8 of a conversion aborts it.
    @(negedge Clk_100M);
    producto = 16'd1234;
    producto_valido = 1'b1;
    @(posedge Clk_100M); #1;
    producto_valido = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge Clk_100M); #1;
    end
    reset = 1'b1;
    @(posedge Clk_100M); #1;
    chk("abort_ocupado", {31'd0, ocupado}, 0);
    chk("abort_an", {24'd0, AN}, 32'hFF);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk_100M); #1;
      if (listo === 1'b1) pulses++;
    end
    chk("abort_no_listo", pulses, 0);
    $display("send abort value=1234 pulses=%0d", pulses);
    check_frame(0, "abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
